mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch requester and an execute-unit
// data requester onto one shared memory bus. A grant latches the winner's
// command into registers that drive the bus for the whole transaction, which
// ends on mem_done or on a busy-cycle timeout (flagged with xfer_err).
//
// Build option: define MEM_ARB_RR_EN to share simultaneous requests
// round-robin; left undefined, the data requester always wins a tie.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [63:0] f_address,
    input  logic [1:0]  f_datasize,
    input  logic        f_read,

    input  logic [63:0] d_address,
    input  logic [1:0]  d_datasize,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [63:0] d_writedata,

    output logic        f_done,
    output logic        d_done,
    output logic        xfer_err,
    output logic [63:0] readdata,

    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Last busy-counter value before the transaction is abandoned.
    localparam logic [15:0] BUSY_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] busy_cnt_q;

    logic [63:0] addr_q;
    logic [1:0]  size_q;
    logic [63:0] wdata_q;
    logic        rd_q;
    logic        wr_q;

    logic f_req;
    logic d_req;
    logic grant_f;
    logic grant_d;
    logic grant;
    logic busy;
    logic timeout;
    logic finish;

    // A data request with both strobes set is a write; either strobe requests.
    assign f_req = f_read;
    assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    // 1: data requester was served last, 0: fetch was served last.
    logic last_d_q;

    // Round-robin tie-break: whoever was not served last wins a tie.
    always_comb begin
        grant_d = d_req & (~f_req | ~last_d_q);
        grant_f = f_req & ~grant_d;
    end

    // Remember who was granted so the next tie goes the other way.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d_q <= 1'b0;
        end else if (grant) begin
            last_d_q <= grant_d;
        end
    end
`else
    // Fixed priority: the data requester always wins a tie.
    always_comb begin
        grant_d = d_req;
        grant_f = f_req & ~d_req;
    end
`endif

    // Grants are only taken while the bus is free.
    assign grant   = (state_q == IDLE) & (grant_f | grant_d);
    assign busy    = (state_q != IDLE);
    // mem_done outranks the timeout when both land in the same cycle.
    assign timeout = busy & ~mem_done & (busy_cnt_q == BUSY_LIMIT);
    assign finish  = busy & (mem_done | timeout);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and completion outputs; done pulses are combinational so the
    // requester sees them in the same cycle mem_done arrives.
    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path can leave a value unassigned and infer a latch.
        state_d  = state_q;
        f_done   = 1'b0;
        d_done   = 1'b0;
        xfer_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_f) begin
                    state_d = BUSY_F;
                end
            end
            BUSY_F: begin
                if (finish) begin
                    f_done   = 1'b1;
                    xfer_err = timeout;
                    state_d  = IDLE;
                end
            end
            BUSY_D: begin
                if (finish) begin
                    d_done   = 1'b1;
                    xfer_err = timeout;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Busy-cycle counter: cleared on grant, counts BUSY cycles without mem_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt_q <= '0;
        end else if (grant) begin
            busy_cnt_q <= '0;
        end else if (busy && !mem_done) begin
            busy_cnt_q <= busy_cnt_q + 16'd1;
        end
    end

    // Command capture on grant; the strobes drop when the transaction ends so
    // the bus command only exists while the arbiter is busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (grant) begin
            if (grant_d) begin
                addr_q  <= d_address;
                size_q  <= d_datasize;
                wdata_q <= d_writedata;
                rd_q    <= d_read & ~d_write;
                wr_q    <= d_write;
            end else begin
                addr_q  <= f_address;
                size_q  <= f_datasize;
                wdata_q <= '0;
                rd_q    <= 1'b1;
                wr_q    <= 1'b0;
            end
        end else if (finish) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end
    end

    assign mem_address   = addr_q;
    assign mem_datasize  = size_q;
    assign mem_writedata = wdata_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign readdata      = mem_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction-level
// model decides the winner of each grant and the outcome (done or timeout)
// from the requests and the memory latency; each task checks one feature.
module tb_mem_arbiter;

    localparam int T = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] f_address;
    logic [1:0]  f_datasize;
    logic        f_read;
    logic [63:0] d_address;
    logic [1:0]  d_datasize;
    logic        d_read;
    logic        d_write;
    logic [63:0] d_writedata;
    logic        f_done;
    logic        d_done;
    logic        xfer_err;
    logic [63:0] readdata;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        mem_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_last_d = 1'b0;   // who the model believes was served last

    mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .f_address    (f_address),
        .f_datasize   (f_datasize),
        .f_read       (f_read),
        .d_address    (d_address),
        .d_datasize   (d_datasize),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_writedata  (d_writedata),
        .f_done       (f_done),
        .d_done       (d_done),
        .xfer_err     (xfer_err),
        .readdata     (readdata),
        .mem_address  (mem_address),
        .mem_datasize (mem_datasize),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_done     (mem_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Tie -> round-robin (not the one served last) or data; otherwise the sole requester.
    function automatic bit pick_data(input bit fr, input bit dreq);
        if (fr && dreq) return RR_EN ? !model_last_d : 1'b1;
        return dreq;
    endfunction

    // One transaction starting in IDLE at posedge+1. lat = busy cycle on which
    // mem_done is raised; lat > T means the memory never answers.
    task automatic run_txn(input bit fr, input bit dr, input bit dw,
                           input logic [63:0] fa, input logic [1:0] fs,
                           input logic [63:0] da, input logic [1:0] ds,
                           input logic [63:0] dwd, input int lat,
                           input string tag, output bit got_d);
        bit          use_d;
        int          last_k;
        logic [67:0] exp_bus;
        logic [2:0]  exp_dn;
        logic [63:0] rdat;
        got_d = 1'b0;
        f_read = fr; f_address = fa; f_datasize = fs;
        d_read = dr; d_write = dw; d_address = da; d_datasize = ds; d_writedata = dwd;
        mem_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s idle_before: rd/wr got %b expected 00", tag, {mem_read, mem_write});
        end
        if (!fr && !(dr || dw)) begin
            @(posedge clk); #1;
            return;
        end
        use_d = pick_data(fr, dr | dw);
        model_last_d = use_d;
        exp_bus = use_d ? {dr & ~dw, dw, ds, da} : {1'b1, 1'b0, fs, fa};
        last_k  = (lat <= T) ? lat : T;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            mem_done     = (k == lat);
            rdat         = rand64();
            mem_readdata = rdat;
            // Requester inputs wander freely; the bus command must not.
            f_read = 1'($urandom); f_address = rand64(); f_datasize = 2'($urandom);
            d_read = 1'($urandom); d_write = 1'($urandom); d_address = rand64();
            d_datasize = 2'($urandom); d_writedata = rand64();
            @(negedge clk);
            n_cmp++;
            if ({mem_read, mem_write, mem_datasize, mem_address} !== exp_bus) begin
                n_bad++;
                $display("FAIL %s bus_cmd cycle %0d: got %h expected %h", tag, k,
                         {mem_read, mem_write, mem_datasize, mem_address}, exp_bus);
            end
            if (use_d && dw) begin
                n_cmp++;
                if (mem_writedata !== dwd) begin
                    n_bad++;
                    $display("FAIL %s writedata cycle %0d: got %h expected %h", tag, k, mem_writedata, dwd);
                end
            end
            exp_dn = {!use_d && k == last_k, use_d && k == last_k, k == last_k && lat > T};
            n_cmp++;
            if ({f_done, d_done, xfer_err} !== exp_dn) begin
                n_bad++;
                $display("FAIL %s done/err cycle %0d: f,d,err got %b expected %b", tag, k,
                         {f_done, d_done, xfer_err}, exp_dn);
            end
            n_cmp++;
            if (readdata !== rdat) begin
                n_bad++;
                $display("FAIL %s readdata: got %h expected %h", tag, readdata, rdat);
            end
            if (k == last_k) got_d = d_done;
        end
        @(posedge clk); #1;
        mem_done = 1'b0; f_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        n_cmp++;
        if ({mem_read, mem_write, f_done, d_done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s idle_after: rd,wr,fd,dd got %b expected 0000", tag,
                     {mem_read, mem_write, f_done, d_done});
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        f_read = 0; f_address = '0; f_datasize = '0;
        d_read = 0; d_write = 0; d_address = '0; d_datasize = '0; d_writedata = '0;
        mem_readdata = '0; mem_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({mem_read, mem_write, f_done, d_done, xfer_err, mem_datasize, mem_address, mem_writedata} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: rd,wr,fd,dd,err got %b addr %h data %h expected all zero",
                     {mem_read, mem_write, f_done, d_done, xfer_err}, mem_address, mem_writedata);
        end
        reset_n = 1'b1;
        model_last_d = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        bit    got_d;
        string exp_order;
        exp_order = RR_EN ? "DFDF" : "DDDD";
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 1, 0, rand64(), 2'($urandom), rand64(), 2'($urandom), rand64(),
                    1 + int'($urandom_range(2)), "priority", got_d);
            n_cmp++;
            if ((got_d ? 8'h44 : 8'h46) !== exp_order[i]) begin
                n_bad++;
                $display("FAIL priority order txn %0d: got %s expected %s", i,
                         got_d ? "D" : "F", RR_EN ? (i % 2 == 0 ? "D" : "F") : "D");
            end
        end
    endtask

    task automatic test_fetch();
        bit got_d;
        run_txn(1, 0, 0, 64'h8000_0000_0000_0000, 2'd2, rand64(), 2'd0, rand64(), 3, "fetch", got_d);
    endtask

    task automatic test_write();
        bit got_d;
        run_txn(0, 0, 1, rand64(), 2'd0, 64'h100, 2'd3, 64'hDEADBEEF_CAFEF00D, 3, "write", got_d);
        // Both strobes set: must be issued as a write only.
        run_txn(0, 1, 1, rand64(), 2'd0, rand64(), 2'd1, rand64(), 2, "rd_and_wr", got_d);
    endtask

    task automatic test_timeout();
        bit got_d;
        run_txn(0, 1, 0, rand64(), 2'd0, rand64(), 2'd3, rand64(), T + 10, "timeout_d", got_d);
        run_txn(1, 0, 0, rand64(), 2'd1, rand64(), 2'd0, rand64(), T + 10, "timeout_f", got_d);
        run_txn(0, 0, 1, rand64(), 2'd2, rand64(), 2'd2, rand64(), T, "done_at_limit", got_d);
        run_txn(1, 0, 0, rand64(), 2'd2, rand64(), 2'd2, rand64(), T - 1, "done_before_limit", got_d);
    endtask

    task automatic test_reset_mid();
        bit got_d;
        d_write = 1'b1; d_read = 1'b0; f_read = 1'b0;
        d_address = rand64(); d_datasize = 2'd3; d_writedata = rand64();
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid busy: mem_write got %b expected 1", mem_write);
        end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_write, mem_read, f_done, d_done, xfer_err, mem_address} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid async: wr,rd,fd,dd,err got %b addr %h expected all zero",
                     {mem_write, mem_read, f_done, d_done, xfer_err}, mem_address);
        end
        d_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_last_d = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_write, mem_read, f_done, d_done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_mid after_release: wr,rd,fd,dd got %b expected 0000",
                     {mem_write, mem_read, f_done, d_done});
        end
        // Pointer must be back at "fetch last": a tie goes to data.
        run_txn(1, 1, 0, rand64(), 2'd1, rand64(), 2'd1, rand64(), 1, "tie_after_reset", got_d);
    endtask

    task automatic test_random();
        bit got_d;
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), rand64(), 2'($urandom),
                    rand64(), 2'($urandom), rand64(), 1 + int'($urandom_range(T)),
                    "random", got_d);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_fetch();
        test_write();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
